// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler for the ISSUE buffer.
//   Looks at the two head entries each cycle (A = older, B = younger) and
//   reports how many are consumed (o_using_num). Keeps a per-register
//   load-latency scoreboard and a serialize FSM for CSR/ERTN/IDLE-class ops.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_is_valid[1:0]               {A valid, B valid}
//   a_* / b_*                     slot sources, destination, write enable, class flags
//   flush_BR                      branch mispredict flush
//   stall_DCache, stall_div       pipeline stalls
//   i_pipe_empty                  EX/MEM/WB hold no valid instruction
//   o_using_num                   instructions consumed this cycle (combinational)
//   o_issue_a, o_issue_b          per-slot issue (combinational)
//   o_ser_busy                    serialize FSM waiting (registered)
module issue_sched #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_is_valid,
  input  logic [4:0] a_rf_raddr1,
  input  logic [4:0] a_rf_raddr2,
  input  logic [4:0] a_rd,
  input  logic       a_we,
  input  logic       a_is_load,
  input  logic       a_is_store,
  input  logic       a_is_br,
  input  logic       a_is_div,
  input  logic       a_is_ser,
  input  logic [4:0] b_rf_raddr1,
  input  logic [4:0] b_rf_raddr2,
  input  logic [4:0] b_rd,
  input  logic       b_we,
  input  logic       b_is_load,
  input  logic       b_is_store,
  input  logic       b_is_br,
  input  logic       b_is_div,
  input  logic       b_is_ser,
  input  logic       flush_BR,
  input  logic       stall_DCache,
  input  logic       stall_div,
  input  logic       i_pipe_empty,
  output logic [1:0] o_using_num,
  output logic       o_issue_a,
  output logic       o_issue_b,
  output logic       o_ser_busy
);

  typedef enum logic {RUN = 1'b0, SER_WAIT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [32];
  logic [31:0]      pend_vec;
  logic             any_pend;
  logic             stall;
  logic             a_valid;
  logic             b_valid;
  logic             raw;
  logic             waw;
  logic             mem_pair;
  logic             pair_ok;

  // A branch in slot B places no constraint on pairing.
  logic unused_bits;
  assign unused_bits = b_is_br;

  // Pending vector: r0 is never pending.
  always_comb begin
    pend_vec = 32'd0;
    for (int i = 1; i < 32; i++) begin
      pend_vec[i] = (cnt[i] != '0);
    end
    any_pend = |pend_vec;
  end

  // Issue decision for both slots.
  always_comb begin
    stall    = stall_DCache | stall_div;
    a_valid  = i_is_valid[1];
    b_valid  = i_is_valid[0];
    raw      = a_we && (a_rd != 5'd0) && ((a_rd == b_rf_raddr1) || (a_rd == b_rf_raddr2));
    waw      = a_we && b_we && (a_rd == b_rd) && (a_rd != 5'd0);
    mem_pair = (a_is_load | a_is_store) && (b_is_load | b_is_store);
    pair_ok  = b_valid && !pend_vec[b_rf_raddr1] && !pend_vec[b_rf_raddr2] &&
               !raw && !waw && !mem_pair && !a_is_br && !b_is_div && !a_is_div && !b_is_ser;
    o_issue_a = 1'b0;
    if (!rst && !flush_BR && !stall && a_valid) begin
      if (state == RUN) begin
        o_issue_a = !pend_vec[a_rf_raddr1] && !pend_vec[a_rf_raddr2] && !a_is_ser;
      end else begin
        // Serialized op goes alone once the machine has fully drained.
        o_issue_a = i_pipe_empty && !any_pend;
      end
    end else begin
      o_issue_a = 1'b0;
    end
    o_issue_b   = o_issue_a && (state == RUN) && pair_ok;
    o_using_num = {1'b0, o_issue_a} + {1'b0, o_issue_b};
  end

  // Load-latency scoreboard: clear on flush, hold on stall, else count down and set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (flush_BR) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (!stall) begin
      for (int i = 0; i < 32; i++) begin
        if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      // Later assignment wins: a fresh load overrides the decrement.
      if (o_issue_a && a_is_load && a_we && (a_rd != 5'd0)) cnt[a_rd] <= CNT_W'(LOAD_LAT);
      if (o_issue_b && b_is_load && b_we && (b_rd != 5'd0)) cnt[b_rd] <= CNT_W'(LOAD_LAT);
    end
  end

  // Serialize FSM with registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      o_ser_busy <= 1'b0;
    end else if (flush_BR) begin
      state      <= RUN;
      o_ser_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (a_valid && a_is_ser) begin
            state      <= SER_WAIT;
            o_ser_busy <= 1'b1;
          end
        end
        SER_WAIT: begin
          if (o_issue_a) begin
            state      <= RUN;
            o_ser_busy <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          o_ser_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
module tb_issue_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_is_valid = 2'b00;
  logic [4:0] a_rf_raddr1 = 5'd0, a_rf_raddr2 = 5'd0, a_rd = 5'd0;
  logic       a_we = 1'b0, a_is_load = 1'b0, a_is_store = 1'b0, a_is_br = 1'b0, a_is_div = 1'b0, a_is_ser = 1'b0;
  logic [4:0] b_rf_raddr1 = 5'd0, b_rf_raddr2 = 5'd0, b_rd = 5'd0;
  logic       b_we = 1'b0, b_is_load = 1'b0, b_is_store = 1'b0, b_is_br = 1'b0, b_is_div = 1'b0, b_is_ser = 1'b0;
  logic       flush_BR = 1'b0, stall_DCache = 1'b0, stall_div = 1'b0, i_pipe_empty = 1'b1;
  logic [1:0] o_using_num;
  logic       o_issue_a, o_issue_b, o_ser_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] un;
    logic       ia;
    logic       ib;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  // class vectors {load, store, br, div, ser}
  localparam logic [4:0] C_ALU = 5'b00000;
  localparam logic [4:0] C_LD  = 5'b10000;
  localparam logic [4:0] C_ST  = 5'b01000;
  localparam logic [4:0] C_BR  = 5'b00100;
  localparam logic [4:0] C_DIV = 5'b00010;
  localparam logic [4:0] C_SER = 5'b00001;

  issue_sched #(.LOAD_LAT(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_is_valid(i_is_valid),
    .a_rf_raddr1(a_rf_raddr1), .a_rf_raddr2(a_rf_raddr2), .a_rd(a_rd), .a_we(a_we),
    .a_is_load(a_is_load), .a_is_store(a_is_store), .a_is_br(a_is_br), .a_is_div(a_is_div), .a_is_ser(a_is_ser),
    .b_rf_raddr1(b_rf_raddr1), .b_rf_raddr2(b_rf_raddr2), .b_rd(b_rd), .b_we(b_we),
    .b_is_load(b_is_load), .b_is_store(b_is_store), .b_is_br(b_is_br), .b_is_div(b_is_div), .b_is_ser(b_is_ser),
    .flush_BR(flush_BR), .stall_DCache(stall_DCache), .stall_div(stall_div), .i_pipe_empty(i_pipe_empty),
    .o_using_num(o_using_num), .o_issue_a(o_issue_a), .o_issue_b(o_issue_b), .o_ser_busy(o_ser_busy)
  );

  always #5 clk = ~clk;

  task automatic set_a(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic we, input logic [4:0] cls);
    a_rf_raddr1 = r1; a_rf_raddr2 = r2; a_rd = rd; a_we = we;
    {a_is_load, a_is_store, a_is_br, a_is_div, a_is_ser} = cls;
  endtask

  task automatic set_b(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic we, input logic [4:0] cls);
    b_rf_raddr1 = r1; b_rf_raddr2 = r2; b_rd = rd; b_we = we;
    {b_is_load, b_is_store, b_is_br, b_is_div, b_is_ser} = cls;
  endtask

  // Push expectation for current inputs, compare at the negedge, then move past the next posedge.
  task automatic step(input string tag, input logic [1:0] un, input logic ia, input logic ib, input logic busy);
    exp_t e;
    exp_q.push_back('{tag, un, ia, ib, busy});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    assert (o_using_num === e.un) else begin
      errors++; $error("FAIL %s using_num got %0d exp %0d", e.tag, o_using_num, e.un);
    end
    checks++;
    assert (o_issue_a === e.ia) else begin
      errors++; $error("FAIL %s issue_a got %0b exp %0b", e.tag, o_issue_a, e.ia);
    end
    checks++;
    assert (o_issue_b === e.ib) else begin
      errors++; $error("FAIL %s issue_b got %0b exp %0b", e.tag, o_issue_b, e.ib);
    end
    checks++;
    assert (o_ser_busy === e.busy) else begin
      errors++; $error("FAIL %s ser_busy got %0b exp %0b", e.tag, o_ser_busy, e.busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: outputs 0 even with a ready pair
    i_is_valid = 2'b11;
    set_a(5'd1, 5'd2, 5'd3, 1'b1, C_ALU);
    set_b(5'd5, 5'd6, 5'd4, 1'b1, C_ALU);
    step("rst_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Independent pair
    step("dual_add", 2'd2, 1'b1, 1'b1, 1'b0);

    // RAW, RAW through r0, WAW
    set_b(5'd3, 5'd4, 5'd7, 1'b1, C_ALU);
    step("raw", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd1, 5'd2, 5'd0, 1'b1, C_ALU);
    set_b(5'd0, 5'd4, 5'd7, 1'b1, C_ALU);
    step("raw_r0", 2'd2, 1'b1, 1'b1, 1'b0);
    set_a(5'd1, 5'd2, 5'd8, 1'b1, C_ALU);
    set_b(5'd9, 5'd10, 5'd8, 1'b1, C_ALU);
    step("waw", 2'd1, 1'b1, 1'b0, 1'b0);

    // Class restrictions
    set_a(5'd1, 5'd2, 5'd0, 1'b0, C_ST);
    set_b(5'd11, 5'd0, 5'd12, 1'b1, C_LD);
    step("st_ld", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd1, 5'd2, 5'd0, 1'b0, C_BR);
    set_b(5'd5, 5'd6, 5'd4, 1'b1, C_ALU);
    step("br_add", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd1, 5'd2, 5'd13, 1'b1, C_DIV);
    step("div_add", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd1, 5'd2, 5'd3, 1'b1, C_ALU);
    set_b(5'd5, 5'd6, 5'd4, 1'b1, C_DIV);
    step("add_div", 2'd1, 1'b1, 1'b0, 1'b0);
    set_b(5'd5, 5'd6, 5'd0, 1'b0, C_SER);
    step("add_ser", 2'd1, 1'b1, 1'b0, 1'b0);

    // Load-use latency
    i_is_valid = 2'b10;
    set_a(5'd1, 5'd0, 5'd5, 1'b1, C_LD);
    step("ld_r5", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd5, 5'd0, 5'd6, 1'b1, C_ALU);
    step("use_t1", 2'd0, 1'b0, 1'b0, 1'b0);
    step("use_t2", 2'd0, 1'b0, 1'b0, 1'b0);
    step("use_t3", 2'd1, 1'b1, 1'b0, 1'b0);

    // Load to r0 never blocks
    set_a(5'd1, 5'd0, 5'd0, 1'b1, C_LD);
    step("ld_r0", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd0, 5'd0, 5'd6, 1'b1, C_ALU);
    step("use_r0", 2'd1, 1'b1, 1'b0, 1'b0);

    // Serialize: wait for empty pipe
    set_a(5'd0, 5'd0, 5'd0, 1'b0, C_SER);
    i_pipe_empty = 1'b0;
    step("ser_enter", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ser_wait", 2'd0, 1'b0, 1'b0, 1'b1);
    i_pipe_empty = 1'b1;
    step("ser_go", 2'd1, 1'b1, 1'b0, 1'b1);
    i_is_valid = 2'b00;
    step("ser_done", 2'd0, 1'b0, 1'b0, 1'b0);

    // Flush while waiting returns to RUN
    i_is_valid = 2'b10;
    i_pipe_empty = 1'b0;
    step("ser_enter2", 2'd0, 1'b0, 1'b0, 1'b0);
    flush_BR = 1'b1;
    step("ser_flush", 2'd0, 1'b0, 1'b0, 1'b1);
    flush_BR = 1'b0;
    i_is_valid = 2'b00;
    i_pipe_empty = 1'b1;
    step("ser_flushed", 2'd0, 1'b0, 1'b0, 1'b0);

    // Stall holds scoreboard; flush clears it
    i_is_valid = 2'b10;
    set_a(5'd1, 5'd0, 5'd5, 1'b1, C_LD);
    step("ld_r5_b", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd5, 5'd0, 5'd6, 1'b1, C_ALU);
    stall_DCache = 1'b1;
    for (int i = 0; i < 4; i++) step("stall", 2'd0, 1'b0, 1'b0, 1'b0);
    stall_DCache = 1'b0;
    step("post_stall", 2'd0, 1'b0, 1'b0, 1'b0);
    flush_BR = 1'b1;
    step("flush", 2'd0, 1'b0, 1'b0, 1'b0);
    flush_BR = 1'b0;
    step("post_flush", 2'd1, 1'b1, 1'b0, 1'b0);
    stall_div = 1'b1;
    step("stall_div", 2'd0, 1'b0, 1'b0, 1'b0);
    stall_div = 1'b0;

    // Reset mid-countdown clears scoreboard
    set_a(5'd1, 5'd0, 5'd5, 1'b1, C_LD);
    step("ld_r5_c", 2'd1, 1'b1, 1'b0, 1'b0);
    set_a(5'd5, 5'd0, 5'd6, 1'b1, C_ALU);
    rst = 1'b1;
    step("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 2'd1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
